radar_burst_controller: RTL

RADAR_BURST_CONTROLLER -- requirements
Module: radar_burst_controller

---
 rtl/radar_ctrl_pkg.sv | 27 ++
 rtl/setting_reg.sv | 23 ++
 rtl/radar_burst_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/radar_ctrl_pkg.sv
// Shared definitions for the radar burst controller: state encoding,
// CTRL word bit positions and settings register offsets.
package radar_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRI_WAIT,
        ST_CHIRP,
        ST_COLLECT,
        ST_HOLDOFF
    } state_t;

    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_MODE_BIT    = 1;
    localparam int CTRL_CLR_OVR_BIT = 2;
    localparam int CTRL_MASK_LSB    = 8;

    localparam int OFS_PRP     = 0;
    localparam int OFS_SAMPLES = 1;
    localparam int OFS_PULSES  = 2;
    localparam int OFS_CTRL    = 3;

    function automatic logic [7:0] reg_addr(input int base, input int ofs);
        return 8'(base + ofs);
    endfunction

endpackage

// File: rtl/setting_reg.sv
// Single addressable settings register written over the settings bus.
module setting_reg #(
    parameter logic [7:0]       ADDR     = 8'd0,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [31:0]      data,
    output logic [WIDTH-1:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            value <= AT_RESET;
        else if (strobe && addr == ADDR)
            value <= data[WIDTH-1:0];
    end

endmodule

// File: rtl/radar_burst_controller.sv
// Radar burst sequencer: paces chirps by the pulse repetition period, gates
// ADC capture per pulse and repeats for the configured number of pulses.
module radar_burst_controller
    import radar_ctrl_pkg::*;
#(
    parameter int          NUM_CH       = 2,
    parameter logic [31:0] PRP_INIT     = 32'd200000,
    parameter logic [31:0] SAMPLES_INIT = 32'd511,
    parameter logic [15:0] PULSES_INIT  = 16'd1,
    parameter int          SR_BASE      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_stb,
    input  logic [7:0]        set_addr,
    input  logic [31:0]       set_data,
    input  logic              trig,
    input  logic              abort,
    input  logic              awg_ready,
    input  logic              awg_active,
    input  logic              awg_done,
    input  logic              awg_data_valid,
    output logic              awg_init,
    output logic              awg_enable,
    output logic [NUM_CH-1:0] adc_enable,
    output logic              adc_run,
    output logic              adc_last,
    output logic [15:0]       pulse_idx,
    output logic              burst_done,
    output logic              busy,
    output logic              overrun
);

    localparam int CTRL_W = NUM_CH + CTRL_MASK_LSB;

    logic [31:0]       prp_cfg, samples_cfg;
    logic [15:0]       pulses_cfg;
    logic [CTRL_W-1:0] ctrl_cfg;

    setting_reg #(.ADDR(reg_addr(SR_BASE, OFS_PRP)), .WIDTH(32), .AT_RESET(PRP_INIT)) u_prp (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr), .data(set_data), .value(prp_cfg));
    setting_reg #(.ADDR(reg_addr(SR_BASE, OFS_SAMPLES)), .WIDTH(32), .AT_RESET(SAMPLES_INIT)) u_samples (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr), .data(set_data), .value(samples_cfg));
    setting_reg #(.ADDR(reg_addr(SR_BASE, OFS_PULSES)), .WIDTH(16), .AT_RESET(PULSES_INIT)) u_pulses (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr), .data(set_data), .value(pulses_cfg));
    setting_reg #(.ADDR(reg_addr(SR_BASE, OFS_CTRL)), .WIDTH(CTRL_W), .AT_RESET('0)) u_ctrl (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr), .data(set_data), .value(ctrl_cfg));

    state_t            state, next_state;
    logic [31:0]       pri_cnt, samp_cnt, prp_w, samples_w;
    logic [15:0]       pulses_w;
    logic [NUM_CH-1:0] mask_w;
    logic              hold_cnt, chirp_first, collect_q;
    logic              awg_enable_d, collect_d, last_d, done_d;
    logic [NUM_CH-1:0] adc_enable_d;

    wire enable      = ctrl_cfg[CTRL_ENABLE_BIT];
    wire mode        = ctrl_cfg[CTRL_MODE_BIT];
    wire clear_ovr   = set_stb && set_addr == reg_addr(SR_BASE, OFS_CTRL) && set_data[CTRL_CLR_OVR_BIT];
    wire arm         = enable && (!mode || trig);
    wire stop        = abort || !enable;
    wire more_pulses = ({1'b0, pulse_idx} + 17'd1) < {1'b0, pulses_w};
    wire hold_done   = state == ST_HOLDOFF && hold_cnt;
    wire in_pulse    = state inside {ST_CHIRP, ST_COLLECT, ST_HOLDOFF};
    wire next_pulse  = next_state inside {ST_CHIRP, ST_COLLECT, ST_HOLDOFF};

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state takes a default first so no path through the block infers a latch.
    always_comb begin
        next_state = state;
        if (state == ST_IDLE) begin
            if (arm) next_state = ST_PRI_WAIT;
        end else if (stop) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_PRI_WAIT: if (pri_cnt == '0 && awg_ready) next_state = ST_CHIRP;
                ST_CHIRP:    if (awg_done) next_state = ST_COLLECT;
                ST_COLLECT:  if (samp_cnt == '0) next_state = ST_HOLDOFF;
                ST_HOLDOFF:  if (hold_cnt) next_state = more_pulses ? ST_PRI_WAIT : ST_IDLE;
                default:     next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        awg_init     = state == ST_CHIRP && chirp_first && !awg_active;
        busy         = state != ST_IDLE;
        adc_run      = !reset && (collect_q || awg_data_valid);
        awg_enable_d = state == ST_CHIRP;
        adc_enable_d = (state inside {ST_CHIRP, ST_COLLECT}) ? mask_w : '0;
        collect_d    = state == ST_COLLECT;
        last_d       = state == ST_COLLECT && samp_cnt == '0;
        done_d       = hold_done && !stop && !more_pulses;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            awg_enable <= 1'b0;
            adc_enable <= '0;
            collect_q  <= 1'b0;
            adc_last   <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            awg_enable <= awg_enable_d;
            adc_enable <= adc_enable_d;
            collect_q  <= collect_d;
            adc_last   <= last_d;
            burst_done <= done_d;
        end
    end

    // Working copies are captured only when a burst starts, so settings writes never disturb a running burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            pri_cnt     <= '0;
            samp_cnt    <= '0;
            hold_cnt    <= 1'b0;
            chirp_first <= 1'b0;
            pulse_idx   <= '0;
            overrun     <= 1'b0;
            prp_w       <= PRP_INIT;
            samples_w   <= SAMPLES_INIT;
            pulses_w    <= (PULSES_INIT == '0) ? 16'd1 : PULSES_INIT;
            mask_w      <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (next_state == ST_PRI_WAIT) begin
                    prp_w     <= prp_cfg;
                    samples_w <= samples_cfg;
                    pulses_w  <= (pulses_cfg == '0) ? 16'd1 : pulses_cfg;
                    mask_w    <= ctrl_cfg[CTRL_W-1:CTRL_MASK_LSB];
                    pri_cnt   <= '0;
                    pulse_idx <= '0;
                end
            end else if (state == ST_PRI_WAIT && next_state == ST_CHIRP) begin
                pri_cnt <= (prp_w == '0) ? '0 : prp_w - 32'd1;
            end else if (pri_cnt != '0) begin
                pri_cnt <= pri_cnt - 32'd1;
            end

            if (state == ST_CHIRP && next_state == ST_COLLECT)
                samp_cnt <= samples_w;
            else if (state == ST_COLLECT && samp_cnt != '0)
                samp_cnt <= samp_cnt - 32'd1;

            hold_cnt    <= state == ST_HOLDOFF && !hold_cnt;
            chirp_first <= state == ST_PRI_WAIT && next_state == ST_CHIRP;

            if (hold_done && next_state == ST_PRI_WAIT)
                pulse_idx <= pulse_idx + 16'd1;

            // Overrun: the period expires while a pulse is still in flight and another pulse is due.
            if (in_pulse && next_pulse && pri_cnt == 32'd1 && more_pulses)
                overrun <= 1'b1;
            else if (clear_ovr)
                overrun <= 1'b0;
        end
    end

endmodule
